// File: rtl/alu_stream_reader_if.sv
// Handshake bundle for the ALU stream reader: command beats in, results out.
// The master side feeds beats and consumes results; the slave side is the reader.
interface alu_stream_reader_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] res_data;
    logic                  res_carry;
    logic                  res_valid;
    logic                  res_ready;

    modport master (
        output in_data, in_valid, res_ready,
        input  in_ready, res_data, res_carry, res_valid
    );

    modport slave (
        input  in_data, in_valid, res_ready,
        output in_ready, res_data, res_carry, res_valid
    );
endinterface

// File: rtl/alu_stream_reader.sv
// Pops three-beat command packets (opcode, A, B) from the packet FIFO, executes
// the ALU operation and holds the registered result until downstream accepts it.
module alu_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk_i,
    input  logic                 arst_n,
    alu_stream_reader_if.slave   bus,
    output logic [CNT_WIDTH-1:0] op_count
);
    localparam int SHW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {GET_OP, GET_A, GET_B, SEND} state_e;

    state_e                state_q, state_d;
    logic [2:0]            opcode_q, opcode_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] res_q, res_d;
    logic                  carry_q, carry_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  in_rdy;

    // Returns {carry, result}; carry is the ADD carry-out or the SUB borrow.
    function automatic logic [DATA_WIDTH:0] alu_exec(
        input logic [2:0]            op,
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic [SHW-1:0] sh;
        sh = b[SHW-1:0];
        case (op)
            3'd0:    alu_exec = {1'b0, a} + {1'b0, b};
            3'd1:    alu_exec = {1'b0, a} - {1'b0, b};
            3'd2:    alu_exec = {1'b0, a & b};
            3'd3:    alu_exec = {1'b0, a | b};
            3'd4:    alu_exec = {1'b0, a ^ b};
            3'd5:    alu_exec = {1'b0, a << sh};
            3'd6:    alu_exec = {1'b0, a >> sh};
            default: alu_exec = {1'b0, a};
        endcase
    endfunction

    always_ff @(posedge clk_i or negedge arst_n) begin
        if (!arst_n) begin
            state_q  <= GET_OP;
            opcode_q <= '0;
            a_q      <= '0;
            res_q    <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            a_q      <= a_d;
            res_q    <= res_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        a_d      = a_q;
        res_d    = res_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        in_rdy   = 1'b0;
        case (state_q)
            GET_OP: begin
                in_rdy = 1'b1;
                if (bus.in_valid) begin
                    opcode_d = bus.in_data[2:0];
                    state_d  = GET_A;
                end
            end
            GET_A: begin
                in_rdy = 1'b1;
                if (bus.in_valid) begin
                    a_d     = bus.in_data;
                    state_d = GET_B;
                end
            end
            GET_B: begin
                in_rdy = 1'b1;
                if (bus.in_valid) begin
                    {carry_d, res_d} = alu_exec(opcode_q, a_q, bus.in_data);
                    state_d          = SEND;
                end
            end
            SEND: begin
                // Result stays frozen until the downstream handshake completes.
                if (bus.res_ready) begin
                    cnt_d   = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                    state_d = GET_OP;
                end
            end
            default: state_d = GET_OP;
        endcase
    end

    assign bus.in_ready  = in_rdy;
    assign bus.res_valid = (state_q == SEND);
    assign bus.res_data  = res_q;
    assign bus.res_carry = carry_q;
    assign op_count      = cnt_q;
endmodule

// File: tb/tb_alu_stream_reader.sv
// Scoreboard bench for alu_stream_reader: directed packets plus randomized traffic.
module tb_alu_stream_reader;
    localparam int DW = 8;
    localparam int CW = 4;

    logic          clk_i = 1'b0;
    logic          arst_n = 1'b0;
    logic [CW-1:0] op_count;

    alu_stream_reader_if #(.DATA_WIDTH(DW)) bus();

    alu_stream_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk_i    (clk_i),
        .arst_n   (arst_n),
        .bus      (bus.slave),
        .op_count (op_count)
    );

    always #5 clk_i = ~clk_i;

    int nvec = 0;
    int nerr = 0;
    int cnt_exp = 0;
    logic [8:0] exp_q[$];
    bit rand_rr = 1'b0;
    bit rr_force = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic over the opcode table.
    function automatic logic [8:0] model(input int op, input int a, input int b);
        int r;
        int c;
        c = 0;
        case (op)
            0: begin r = a + b; c = (r > 255) ? 1 : 0; r = r % 256; end
            1: begin c = (a < b) ? 1 : 0; r = (a - b + 256) % 256; end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = (a * (2 ** (b % 8))) % 256;
            6: r = a / (2 ** (b % 8));
            default: r = a;
        endcase
        return {c[0], r[7:0]};
    endfunction

    always @(posedge clk_i) begin
        #1;
        bus.res_ready = rand_rr ? 1'($urandom_range(0, 1)) : rr_force;
    end

    // Monitor: every delivered result is compared against the scoreboard head.
    always @(negedge clk_i) begin
        if (arst_n && bus.res_valid && bus.res_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 32'(bus.res_data), 32'hFFFF_FFFF);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                check("res_data", 32'(bus.res_data), 32'(e[7:0]));
                check("res_carry", 32'(bus.res_carry), 32'(e[8]));
            end
            check("op_count_at_delivery", 32'(op_count), 32'(cnt_exp));
            cnt_exp = (cnt_exp + 1) % (2 ** CW);
        end
    end

    task automatic send_beat(input logic [7:0] d, input int gap);
        int n;
        for (int i = 0; i < gap; i++) begin
            @(negedge clk_i);
            bus.in_valid = 1'b0;
            bus.in_data  = 8'($urandom);
        end
        @(negedge clk_i);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        n = 0;
        while (!bus.in_ready) begin
            @(negedge clk_i);
            n++;
            if (n > 200) begin
                check("beat_timeout", 32'(n), 32'd0);
                break;
            end
        end
        @(posedge clk_i);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
    endtask

    task automatic send_pkt(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                            input int gap);
        send_beat(op, gap);
        send_beat(a, gap);
        send_beat(b, gap);
        exp_q.push_back(model(int'(op[2:0]), int'(a), int'(b)));
    endtask

    task automatic check_res(input string name, input logic [7:0] d, input logic c);
        check({name, "_valid"}, 32'(bus.res_valid), 32'd1);
        check({name, "_data"}, 32'(bus.res_data), 32'(d));
        check({name, "_carry"}, 32'(bus.res_carry), 32'(c));
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    initial begin
        logic [CW-1:0] cnt_before;
        int t;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.res_ready = 1'b1;
        idle(2);
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_res_data", 32'(bus.res_data), 32'd0);
        check("rst_op_count", 32'(op_count), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        arst_n = 1'b1;
        idle(2);

        send_pkt(8'h00, 8'hF0, 8'h20, 0);
        check_res("add_carry", 8'h10, 1'b1);
        idle(2);
        check("op_count_first", 32'(op_count), 32'd1);

        send_pkt(8'h01, 8'h05, 8'h07, 0);
        check_res("sub_borrow", 8'hFE, 1'b1);
        send_pkt(8'hFC, 8'hA5, 8'h0F, 0);
        check_res("xor_upper_ignored", 8'hAA, 1'b0);
        send_pkt(8'h05, 8'h81, 8'h09, 0);
        check_res("shl", 8'h02, 1'b0);
        send_pkt(8'h06, 8'h80, 8'h07, 0);
        check_res("shr", 8'h01, 1'b0);
        idle(2);

        rr_force = 1'b0;
        idle(2);
        cnt_before = op_count;
        send_pkt(8'h00, 8'h03, 8'h04, 0);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'($urandom);
            @(negedge clk_i);
            check("stall_valid", 32'(bus.res_valid), 32'd1);
            check("stall_data", 32'(bus.res_data), 32'h07);
            check("stall_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid = 1'b0;
        rr_force = 1'b1;
        idle(4);
        check("stall_single_delivery", 32'(op_count), 32'(CW'(cnt_before + 1'b1)));
        check("stall_released", 32'(bus.res_valid), 32'd0);

        cnt_before = op_count;
        send_pkt(8'h02, 8'hCC, 8'h0F, 1);
        check_res("gapped_and", 8'h0C, 1'b0);
        idle(3);
        check("gapped_one_result", 32'(op_count), 32'(CW'(cnt_before + 1'b1)));

        send_beat(8'h03, 0);
        send_beat(8'h11, 0);
        #3;
        arst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(bus.res_valid), 32'd0);
        check("async_rst_data", 32'(bus.res_data), 32'd0);
        check("async_rst_carry", 32'(bus.res_carry), 32'd0);
        check("async_rst_count", 32'(op_count), 32'd0);
        exp_q.delete();
        cnt_exp = 0;
        idle(2);
        arst_n = 1'b1;
        send_pkt(8'h07, 8'h5A, 8'h00, 0);
        check_res("pass_after_rst", 8'h5A, 1'b0);
        idle(2);
        check("count_after_rst", 32'(op_count), 32'd1);

        rand_rr = 1'b1;
        for (int p = 0; p < 160; p++) begin
            send_pkt(8'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 2)));
        end
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge clk_i);
            t++;
        end
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        idle(2);
        check("final_op_count", 32'(op_count), 32'(cnt_exp));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
